// File: rtl/msx_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package : msx_bus_pkg
// Purpose : Shared constants and types for the MSX slot-bus initiator.
// Rev     : 1.0  initial release
// ============================================================================
package msx_bus_pkg;

  localparam int DEFAULT_DIV        = 30;
  localparam int DEFAULT_WAIT_LIMIT = 255;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4,
    ST_GAP  = 3'd5
  } bus_state_t;

  // Command fields still needed after T1 entry (the address goes straight to BUS_ADDR)
  typedef struct packed {
    logic       wr;
    logic       io;
    logic [7:0] wdata;
  } bus_cmd_t;

endpackage
`default_nettype wire

// File: rtl/tstate_divider.sv
`default_nettype none
// ============================================================================
// Module  : tstate_divider
// Purpose : Down-counter DIV-1..0 producing a one-cycle T-state strobe.
// Rev     : 1.0  initial release
// ============================================================================
module tstate_divider
  import msx_bus_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic CLK_BASE,
  input  logic RESET_n,
  output logic tick
);

  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK_BASE or negedge RESET_n) begin
    if (!RESET_n) begin
      count <= RELOAD;
    end else if (count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - CW'(1);
    end
  end

  assign tick = (count == '0);

endmodule
`default_nettype wire

// File: rtl/msx_bus_initiator.sv
`default_nettype none
// ============================================================================
// Module  : msx_bus_initiator
// Purpose : MSX cartridge-slot bus master; one bus T-state per BUS_CLK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module msx_bus_initiator
  import msx_bus_pkg::*;
#(
  parameter int DIV        = DEFAULT_DIV,
  parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic        CLK_BASE,
  input  logic        RESET_n,
  input  logic        CMD_REQ,
  input  logic        CMD_WR,
  input  logic        CMD_IO,
  input  logic [15:0] CMD_ADDR,
  input  logic [7:0]  CMD_WDATA,
  output logic        CMD_ACK,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_BUSDIR,
  output logic        RSP_TIMEOUT,
  output logic        BUS_CLK_EN,
  output logic [15:0] BUS_ADDR,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_SLTSL_n,
  output logic        BUS_MREQ_n,
  output logic        BUS_IORQ_n,
  output logic        BUS_RD_n,
  output logic        BUS_WR_n,
  input  logic [7:0]  BUS_DIN,
  input  logic        BUS_WAIT_n,
  input  logic        BUS_BUSDIR_n
);

  localparam logic [8:0] LIMIT = 9'(WAIT_LIMIT);

  bus_state_t state;
  bus_cmd_t   cmd;
  logic [7:0] wait_cnt;
  logic       wait_expired;
  logic       abort_cycle;
  logic       end_cycle;

  tstate_divider #(
    .DIV (DIV)
  ) u_tstate_divider (
    .CLK_BASE (CLK_BASE),
    .RESET_n  (RESET_n),
    .tick     (BUS_CLK_EN)
  );

  // wait_cnt holds completed TW states; the TW now ending would be number wait_cnt+1
  assign wait_expired = ({1'b0, wait_cnt} + 9'd1) >= LIMIT;
  assign abort_cycle  = (state == ST_TW) && !BUS_WAIT_n && wait_expired;
  assign end_cycle    = (state == ST_T3) || abort_cycle;

  always_ff @(posedge CLK_BASE or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= ST_IDLE;
      cmd         <= '0;
      wait_cnt    <= '0;
      CMD_ACK     <= 1'b0;
      RSP_VALID   <= 1'b0;
      RSP_RDATA   <= '0;
      RSP_BUSDIR  <= 1'b0;
      RSP_TIMEOUT <= 1'b0;
      BUS_ADDR    <= '0;
      BUS_DOUT    <= '0;
      BUS_SLTSL_n <= 1'b1;
      BUS_MREQ_n  <= 1'b1;
      BUS_IORQ_n  <= 1'b1;
      BUS_RD_n    <= 1'b1;
      BUS_WR_n    <= 1'b1;
    end else begin
      CMD_ACK   <= 1'b0;
      RSP_VALID <= 1'b0;
      if (BUS_CLK_EN) begin
        if (end_cycle) begin
          BUS_SLTSL_n <= 1'b1;
          BUS_MREQ_n  <= 1'b1;
          BUS_IORQ_n  <= 1'b1;
          BUS_RD_n    <= 1'b1;
          BUS_WR_n    <= 1'b1;
          RSP_VALID   <= 1'b1;
          RSP_TIMEOUT <= abort_cycle;
          RSP_BUSDIR  <= ~BUS_BUSDIR_n;
          if (abort_cycle) begin
            RSP_RDATA <= 8'hFF;
          end else if (!cmd.wr) begin
            RSP_RDATA <= BUS_DIN;
          end
          state <= ST_GAP;
        end else begin
          case (state)
            ST_IDLE: begin
              if (CMD_REQ) begin
                cmd         <= '{wr: CMD_WR, io: CMD_IO, wdata: CMD_WDATA};
                CMD_ACK     <= 1'b1;
                BUS_ADDR    <= CMD_ADDR;
                BUS_MREQ_n  <= CMD_IO;
                BUS_SLTSL_n <= CMD_IO;
                BUS_IORQ_n  <= ~CMD_IO;
                BUS_RD_n    <= CMD_WR;
                wait_cnt    <= '0;
                state       <= ST_T1;
              end
            end
            ST_T1: begin
              if (cmd.wr) begin
                BUS_WR_n <= 1'b0;
                BUS_DOUT <= cmd.wdata;
              end
              state <= ST_T2;
            end
            // I/O cycles always take one TW before WAIT_n is looked at
            ST_T2: begin
              if (cmd.io || !BUS_WAIT_n) begin
                state <= ST_TW;
              end else begin
                state <= ST_T3;
              end
            end
            ST_TW: begin
              if (BUS_WAIT_n) begin
                state <= ST_T3;
              end else begin
                wait_cnt <= wait_cnt + 8'd1;
              end
            end
            ST_GAP: begin
              state <= ST_IDLE;
            end
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msx_bus_initiator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_msx_bus_initiator
// Purpose : Directed table, corner sequences and random cycles for the initiator.
// Rev     : 1.0  initial release
// ============================================================================
module tb_msx_bus_initiator;

  localparam int DIV        = 30;
  localparam int WAIT_LIMIT = 255;

  logic        CLK_BASE     = 1'b0;
  logic        RESET_n      = 1'b0;
  logic        CMD_REQ      = 1'b0;
  logic        CMD_WR       = 1'b0;
  logic        CMD_IO       = 1'b0;
  logic [15:0] CMD_ADDR     = '0;
  logic [7:0]  CMD_WDATA    = '0;
  logic [7:0]  BUS_DIN      = '0;
  logic        BUS_WAIT_n   = 1'b1;
  logic        BUS_BUSDIR_n = 1'b1;
  logic        CMD_ACK, RSP_VALID, RSP_BUSDIR, RSP_TIMEOUT, BUS_CLK_EN;
  logic [7:0]  RSP_RDATA, BUS_DOUT;
  logic [15:0] BUS_ADDR;
  logic        BUS_SLTSL_n, BUS_MREQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n;

  msx_bus_initiator #(
    .DIV        (DIV),
    .WAIT_LIMIT (WAIT_LIMIT)
  ) dut (
    .CLK_BASE     (CLK_BASE),
    .RESET_n      (RESET_n),
    .CMD_REQ      (CMD_REQ),
    .CMD_WR       (CMD_WR),
    .CMD_IO       (CMD_IO),
    .CMD_ADDR     (CMD_ADDR),
    .CMD_WDATA    (CMD_WDATA),
    .CMD_ACK      (CMD_ACK),
    .RSP_VALID    (RSP_VALID),
    .RSP_RDATA    (RSP_RDATA),
    .RSP_BUSDIR   (RSP_BUSDIR),
    .RSP_TIMEOUT  (RSP_TIMEOUT),
    .BUS_CLK_EN   (BUS_CLK_EN),
    .BUS_ADDR     (BUS_ADDR),
    .BUS_DOUT     (BUS_DOUT),
    .BUS_SLTSL_n  (BUS_SLTSL_n),
    .BUS_MREQ_n   (BUS_MREQ_n),
    .BUS_IORQ_n   (BUS_IORQ_n),
    .BUS_RD_n     (BUS_RD_n),
    .BUS_WR_n     (BUS_WR_n),
    .BUS_DIN      (BUS_DIN),
    .BUS_WAIT_n   (BUS_WAIT_n),
    .BUS_BUSDIR_n (BUS_BUSDIR_n)
  );

  always #5 CLK_BASE = ~CLK_BASE;

  int cyc = 0;
  always @(posedge CLK_BASE) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        wr;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        bdn;
    int          w;          // WAIT_n low samples the responder asks for
    int          exp_len;    // T-states from T1 entry to the response
    logic [7:0]  exp_rdata;
    logic        exp_busdir;
    logic        exp_to;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Cycle length: T1,T2,(forced I/O TW),W waits,T3 -- or T1,T2 plus WAIT_LIMIT TWs on abort
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   tw;
    r            = v;
    tw           = (v.io ? 1 : 0) + v.w;
    r.exp_to     = (tw > WAIT_LIMIT);
    r.exp_len    = r.exp_to ? 2 + WAIT_LIMIT : 3 + tw;
    r.exp_rdata  = r.exp_to ? 8'hFF : v.din;
    r.exp_busdir = ~v.bdn;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK_BASE);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n0, rsp_at, acks, rd_c, wr_c, mr_c, io_c, sl_c, first, k, len;
    bit proto_err, data_err, gap_err;
    logic [7:0] rdata;
    logic busdir, to;
    n0 = -1; rsp_at = -1; acks = 0;
    rd_c = 0; wr_c = 0; mr_c = 0; io_c = 0; sl_c = 0;
    proto_err = 0; data_err = 0; gap_err = 0;
    rdata = '0; busdir = 1'b0; to = 1'b0;
    first = v.io ? 3 : 2;
    len   = v.exp_len;
    CMD_WR = v.wr; CMD_IO = v.io; CMD_ADDR = v.addr; CMD_WDATA = v.wdata; CMD_REQ = 1'b1;
    BUS_DIN = v.din; BUS_BUSDIR_n = v.bdn; BUS_WAIT_n = 1'b1;
    for (int c = 0; c < 12000 && rsp_at < 0; c++) begin
      tick();
      if (CMD_ACK) begin
        acks++;
        CMD_REQ   = 1'b0;
        CMD_WR    = 1'($urandom);
        CMD_IO    = 1'($urandom);
        CMD_ADDR  = 16'($urandom);
        CMD_WDATA = 8'($urandom);
      end
      if (n0 < 0 && (!BUS_MREQ_n || !BUS_IORQ_n)) n0 = cyc;
      if (!BUS_RD_n)    rd_c++;
      if (!BUS_WR_n)    wr_c++;
      if (!BUS_MREQ_n)  mr_c++;
      if (!BUS_IORQ_n)  io_c++;
      if (!BUS_SLTSL_n) sl_c++;
      if (!BUS_RD_n && !BUS_WR_n)     proto_err = 1;
      if (!BUS_MREQ_n && !BUS_IORQ_n) proto_err = 1;
      if ((!BUS_MREQ_n || !BUS_IORQ_n) && BUS_ADDR !== v.addr) data_err = 1;
      if (!BUS_WR_n && BUS_DOUT !== v.wdata) data_err = 1;
      if (RSP_VALID) begin
        rsp_at = cyc; rdata = RSP_RDATA; busdir = RSP_BUSDIR; to = RSP_TIMEOUT;
      end
      // WAIT_n for the next T-state boundary; boundary k ends the k-th T-state after T1 entry
      if (n0 >= 0 && rsp_at < 0) begin
        k = (cyc - n0) / DIV + 1;
        BUS_WAIT_n = !(k >= first && k < first + v.w);
      end else begin
        BUS_WAIT_n = 1'b1;
      end
    end
    BUS_WAIT_n = 1'b1;
    check({tag, ".rsp_seen"}, (rsp_at >= 0), 1);
    check({tag, ".t1_seen"}, (n0 >= 0), 1);
    check({tag, ".latency"}, rsp_at - n0, len * DIV);
    check({tag, ".acks"}, acks, 1);
    check({tag, ".timeout"}, to, v.exp_to);
    if (!v.wr || v.exp_to) check({tag, ".rdata"}, rdata, v.exp_rdata);
    if (!v.exp_to) check({tag, ".busdir"}, busdir, v.exp_busdir);
    check({tag, ".rd_cycles"}, rd_c, v.wr ? 0 : len * DIV);
    check({tag, ".wr_cycles"}, wr_c, v.wr ? (len - 1) * DIV : 0);
    check({tag, ".mreq_cycles"}, mr_c, v.io ? 0 : len * DIV);
    check({tag, ".sltsl_cycles"}, sl_c, v.io ? 0 : len * DIV);
    check({tag, ".iorq_cycles"}, io_c, v.io ? len * DIV : 0);
    check({tag, ".strobe_exclusive"}, proto_err, 0);
    check({tag, ".addr_dout"}, data_err, 0);
    for (int c = 0; c < 2 * DIV; c++) begin
      tick();
      if (!BUS_MREQ_n || !BUS_IORQ_n || !BUS_RD_n || !BUS_WR_n || !BUS_SLTSL_n ||
          RSP_VALID || CMD_ACK) gap_err = 1;
    end
    check({tag, ".quiet_after"}, gap_err, 0);
  endtask

  task automatic release_and_time(input string tag);
    int n, m;
    bit rsp_seen;
    rsp_seen = 0;
    @(posedge CLK_BASE);
    #1;
    RESET_n = 1'b1;
    n = 0;
    while (n < 4 * DIV) begin
      tick(); n++;
      if (RSP_VALID) rsp_seen = 1;
      if (BUS_CLK_EN) break;
    end
    check({tag, ".first_clk_en"}, n, DIV - 1);
    m = 0;
    while (m < 4 * DIV) begin
      tick(); m++;
      if (RSP_VALID) rsp_seen = 1;
      if (BUS_CLK_EN) break;
    end
    check({tag, ".clk_en_period"}, m, DIV);
    check({tag, ".no_rsp"}, rsp_seen, 0);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    int wr_seen, acks, t1s, rsps, run_high, gap, extra_acks;
    bit prev_act, act, rsp_in_reset;

    //        wr    io    addr      wdata  din    bdn   w     len  rdata  busdir to
    tbl[0] = '{1'b0, 1'b0, 16'h4000, 8'h00, 8'hA5, 1'b0, 0,    3,   8'hA5, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h7FFE, 8'h3C, 8'h00, 1'b1, 0,    3,   8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'h0098, 8'h00, 8'h5A, 1'b0, 2,    6,   8'h5A, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 16'h1234, 8'h00, 8'h12, 1'b0, 1000, 257, 8'hFF, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 16'h8001, 8'h00, 8'h77, 1'b1, 0,    3,   8'h77, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 16'h00A0, 8'h81, 8'h00, 1'b0, 0,    4,   8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'hC000, 8'h00, 8'h3E, 1'b0, 255,  258, 8'h3E, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 16'h0099, 8'h55, 8'h00, 1'b1, 255,  257, 8'hFF, 1'b0, 1'b1};

    RESET_n = 1'b0;
    repeat (3) tick();
    check("reset.strobes", {BUS_SLTSL_n, BUS_MREQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n}, 5'h1F);
    check("reset.bus", {BUS_ADDR, BUS_DOUT}, 0);
    check("reset.rsp", {CMD_ACK, RSP_VALID, RSP_RDATA, RSP_BUSDIR, RSP_TIMEOUT, BUS_CLK_EN}, 0);
    release_and_time("por");

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Reset dropped while a write sits in wait states
    CMD_WR = 1'b1; CMD_IO = 1'b0; CMD_ADDR = 16'h5555; CMD_WDATA = 8'hAA; CMD_REQ = 1'b1;
    BUS_WAIT_n = 1'b0; BUS_BUSDIR_n = 1'b1;
    wr_seen = 0;
    for (int c = 0; c < 10 * DIV; c++) begin
      tick();
      if (CMD_ACK) CMD_REQ = 1'b0;
      if (!BUS_WR_n) wr_seen++;
      if (wr_seen >= 3 * DIV) break;
    end
    check("midrst.reached_tw", wr_seen, 3 * DIV);
    #2;
    RESET_n = 1'b0;
    #1;
    check("midrst.strobes_async", {BUS_SLTSL_n, BUS_MREQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n}, 5'h1F);
    check("midrst.outputs_async", {BUS_ADDR, RSP_VALID, CMD_ACK}, 0);
    BUS_WAIT_n = 1'b1;
    rsp_in_reset = 0;
    repeat (3) begin
      tick();
      if (RSP_VALID) rsp_in_reset = 1;
    end
    check("midrst.no_rsp_in_reset", rsp_in_reset, 0);
    release_and_time("midrst");
    run_txn(tbl[1], "midrst.next");

    // Back-to-back requests with CMD_REQ held high
    CMD_WR = 1'b0; CMD_IO = 1'b0; CMD_ADDR = 16'h2000; CMD_WDATA = 8'h00;
    BUS_DIN = 8'h11; BUS_BUSDIR_n = 1'b0; BUS_WAIT_n = 1'b1; CMD_REQ = 1'b1;
    acks = 0; t1s = 0; rsps = 0; run_high = 0; gap = -1; prev_act = 0;
    for (int c = 0; c < 20 * DIV && rsps < 2; c++) begin
      tick();
      act = !BUS_MREQ_n || !BUS_IORQ_n || !BUS_RD_n || !BUS_WR_n || !BUS_SLTSL_n;
      if (CMD_ACK) begin
        acks++;
        if (acks == 2) CMD_REQ = 1'b0;
      end
      if (act && !prev_act) begin
        t1s++;
        if (rsps == 1) gap = run_high;
      end
      run_high = act ? 0 : run_high + 1;
      if (RSP_VALID) rsps++;
      prev_act = act;
    end
    extra_acks = 0;
    for (int c = 0; c < 3 * DIV; c++) begin
      tick();
      if (CMD_ACK) extra_acks++;
    end
    check("b2b.acks", acks + extra_acks, 2);
    check("b2b.t1_entries", t1s, 2);
    check("b2b.responses", rsps, 2);
    check("b2b.gap_at_least_one_tstate", (gap >= DIV), 1);

    // Random cycles against the reference model
    for (int i = 0; i < 16; i++) begin
      rv.wr    = 1'($urandom);
      rv.io    = 1'($urandom);
      rv.addr  = 16'($urandom);
      rv.wdata = 8'($urandom);
      rv.din   = 8'($urandom);
      rv.bdn   = 1'($urandom);
      rv.w     = int'($urandom_range(0, 4));
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
